pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Program-counter and instruction-fetch stage of the RV32I core. Holds the PC and fetches one
//  instruction at a time from instruction memory over a req/ack handshake. Presents the word to
//  the decoder and control unit, which drive CUOp/imm into the sign extender.
//  Computes the next PC from the sign-extended immediate (immOut) plus branch/jump decisions.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset; first fetch address
//  XLEN       32              data/address width
// PORTS
//  clk           in   1     system clock, rising-edge
//  nRst          in   1     synchronous active-low reset
//  imem_req      out  1     fetch request to instruction memory
//  imem_addr     out  XLEN  fetch address, word-aligned
//  imem_ack      in   1     memory has valid imem_rdata this cycle
//  imem_rdata    in   XLEN  fetched instruction word
//  instr         out  XLEN  latched instruction for the decoder
//  instr_pc      out  XLEN  address instr was fetched from
//  instr_valid   out  1     instr/instr_pc valid, held until consumed
//  instr_ready   in   1     downstream has finished with instr (retire)
//  branch_taken  in   1     conditional branch resolved taken (sampled with instr_ready)
//  jump          in   1     JAL
//  jalr          in   1     JALR
//  imm           in   XLEN  sign-extended byte offset (sign extender immOut)
//  jalr_base     in   XLEN  rs1 value for JALR
//  halt          in   1     stop fetching after the current instruction retires
//  halted        out  1     fetch stopped (halt or misaligned target)
//  misaligned    out  1     sticky: next-PC target not 4-byte aligned
// BEHAVIOUR
//  States: REQ, HOLD, STOP. Reset (nRst low at rising edge): state=REQ, pc=RESET_PC,
//   imem_req=0, instr=0, instr_pc=0, instr_valid=0, halted=0, misaligned=0.
//   Reset mid-fetch abandons the request; an ack arriving while nRst is low is ignored.
//  REQ: imem_req=1, imem_addr=pc. Both are held stable until imem_ack is seen.
//   imem_req rises the first cycle after reset release.
//   On imem_ack: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, imem_req<=0, go HOLD.
//   Ack may arrive in the first req cycle, giving valid 1 cycle after req asserts.
//   imem_ack while imem_req=0 is ignored.
//  HOLD: instr_valid=1, outputs stable, imem_req=0. Wait for instr_ready.
//   On instr_ready, next-PC priority: jalr -> (jalr_base+imm) & ~1;
//   else jump|branch_taken -> instr_pc+imm; else instr_pc+4.
//   All adds are modulo 2^XLEN (wrap, no flag).
//   Misaligned check: if next_pc[1:0]!=0, set misaligned=1 and halted=1, go STOP, and do not
//   update pc. Otherwise, if halt=1, set halted=1 and go STOP. Otherwise pc<=next_pc, go REQ.
//   Going REQ/STOP also clears instr_valid.
//   branch_taken/jump/jalr/halt/imm are sampled only when instr_valid&instr_ready;
//   they are ignored at all other times.
//  STOP: imem_req=0, instr_valid=0, halted=1. Only reset exits.
//  Throughput: one instruction per (mem latency + 1 HOLD cycle min). Ready in the first HOLD
//   cycle gives the next req on the following cycle.
// TESTING
//  1 reset, ack 1 cycle after req -> imem_addr=0, instr=imem_rdata, instr_pc=0,
//    valid 1 cycle after ack edge.
//  2 sequential: 3 fetches, ready each time -> imem_addr 0x0,0x4,0x8; no req while valid.
//  3 branch_taken=1 imm=0xFFFF_FFF8 at pc 0x10 -> next imem_addr 0x08;
//    jump imm=0x100 at 0x08 -> 0x108.
//  4 jalr base=0x203 imm=0x1 -> addr 0x204; jalr base=0x200 imm=0x2 -> misaligned=1,
//    halted=1, no further req.
//  5 ack delayed 5 cycles -> imem_req/imem_addr stable throughout; pc=0xFFFF_FFFC
//    sequential wraps to 0x0.
//  6 nRst low during REQ with ack same cycle -> instr_valid stays 0, restart at RESET_PC;
//    halt with ready -> STOP, ack ignored.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: instruction-memory req/ack bus plus the decoder-facing
// instruction handoff and next-PC control inputs.
interface pc_fetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            branch_taken;
    logic            jump;
    logic            jalr;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] jalr_base;
    logic            halt;
    logic            halted;
    logic            misaligned;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output instr, instr_pc, instr_valid,
        input  instr_ready, branch_taken, jump, jalr, imm, jalr_base, halt,
        output halted, misaligned
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  instr, instr_pc, instr_valid,
        output instr_ready, branch_taken, jump, jalr, imm, jalr_base, halt,
        input  halted, misaligned
    );
endinterface

// File: rtl/pc_fetch.sv
// RV32I program counter and instruction fetch: one outstanding req/ack fetch,
// instruction held for the decoder until retired, then next-PC selection.
module pc_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic       clk,
    input  logic       nRst,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] instr_reg, instr_next;
    logic [XLEN-1:0] instr_pc_reg, instr_pc_next;
    logic            req_reg, req_next;
    logic            valid_reg, valid_next;
    logic            halted_reg, halted_next;
    logic            mis_reg, mis_next;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    // Next-PC candidate, only consumed when the held instruction retires
    always_comb begin
        jalr_sum = bus.jalr_base + bus.imm;
        if (bus.jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end else if (bus.jump || bus.branch_taken) begin
            target = instr_pc_reg + bus.imm;
        end else begin
            target = instr_pc_reg + XLEN'(4);
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        req_next      = req_reg;
        valid_next    = valid_reg;
        halted_next   = halted_reg;
        mis_next      = mis_reg;
        case (state_reg)
            S_REQ: begin
                // Request comes up one cycle after reset; acks before that are ignored
                if (!req_reg) begin
                    req_next = 1'b1;
                end else if (bus.imem_ack) begin
                    instr_next    = bus.imem_rdata;
                    instr_pc_next = pc_reg;
                    valid_next    = 1'b1;
                    req_next      = 1'b0;
                    state_next    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.instr_ready) begin
                    valid_next = 1'b0;
                    if (target[1:0] != 2'b00) begin
                        mis_next    = 1'b1;
                        halted_next = 1'b1;
                        state_next  = S_STOP;
                    end else if (bus.halt) begin
                        halted_next = 1'b1;
                        state_next  = S_STOP;
                    end else begin
                        pc_next    = target;
                        req_next   = 1'b1;
                        state_next = S_REQ;
                    end
                end
            end
            S_STOP: begin
                req_next    = 1'b0;
                valid_next  = 1'b0;
                halted_next = 1'b1;
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_reg <= S_REQ;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            req_reg      <= 1'b0;
            valid_reg    <= 1'b0;
            halted_reg   <= 1'b0;
            mis_reg      <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            req_reg      <= req_next;
            valid_reg    <= valid_next;
            halted_reg   <= halted_next;
            mis_reg      <= mis_next;
        end
    end

    assign bus.imem_req    = req_reg;
    assign bus.imem_addr   = pc_reg;
    assign bus.instr       = instr_reg;
    assign bus.instr_pc    = instr_pc_reg;
    assign bus.instr_valid = valid_reg;
    assign bus.halted      = halted_reg;
    assign bus.misaligned  = mis_reg;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a transaction-level fetch/retire model plus a
// per-cycle compare of every DUT output against it.
module tb_pc_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    pc_fetch_if #(.XLEN(32)) bus ();

    pc_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // Expected architectural view of the fetch stage
    logic [31:0] m_pc, m_instr, m_instr_pc;
    logic        m_req, m_valid, m_halted, m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_req", 32'(bus.imem_req), 32'(m_req));
            if (m_req) chk("imem_addr", bus.imem_addr, m_pc);
            chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
            if (m_valid) begin
                chk("instr", bus.instr, m_instr);
                chk("instr_pc", bus.instr_pc, m_instr_pc);
            end
            chk("halted", 32'(bus.halted), 32'(m_halted));
            chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
        end
    end

    task automatic m_reset;
        m_pc = RESET_PC; m_instr = '0; m_instr_pc = '0;
        m_req = 1'b0; m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
    endtask

    task automatic clear_ctrl;
        bus.instr_ready = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
        bus.jalr = 1'b0; bus.halt = 1'b0; bus.imm = '0; bus.jalr_base = '0;
    endtask

    task automatic do_reset(input logic ack_during);
        nRst = 1'b0;
        bus.imem_ack = ack_during;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        m_reset();
        chk_en = 1'b1;
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk); #1;
        m_req = 1'b1;
        $display("reset (ack_during=%0b) done", ack_during);
    endtask

    // Wait lat cycles with noise on the retire controls, then ack with rdata
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] rdata, input int lat);
        for (int i = 0; i < lat; i++) begin
            bus.instr_ready = 1'b1; bus.halt = 1'b1; bus.jalr = 1'b1;
            @(posedge clk); #1;
        end
        clear_ctrl();
        bus.imem_ack = 1'b1;
        bus.imem_rdata = rdata;
        @(negedge clk);
        chk("fetch_addr_lit", bus.imem_addr, exp_addr);
        chk("fetch_req_lit", 32'(bus.imem_req), 32'd1);
        @(posedge clk); #1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        m_valid = 1'b1; m_instr = rdata; m_instr_pc = m_pc; m_req = 1'b0;
        $display("fetch addr=0x%08h data=0x%08h lat=%0d", exp_addr, rdata, lat);
    endtask

    task automatic retire(input int hold, input logic br, input logic jmp, input logic jr,
                          input logic [31:0] imm, input logic [31:0] base, input logic hlt);
        logic [31:0] nxt;
        for (int i = 0; i < hold; i++) begin
            bus.jalr = 1'b1; bus.halt = 1'b1; bus.imm = $urandom;
            @(posedge clk); #1;
        end
        bus.instr_ready = 1'b1; bus.branch_taken = br; bus.jump = jmp; bus.jalr = jr;
        bus.imm = imm; bus.jalr_base = base; bus.halt = hlt;
        @(posedge clk); #1;
        clear_ctrl();
        if (jr)              nxt = (base + imm) & ~32'd1;
        else if (jmp || br)  nxt = m_instr_pc + imm;
        else                 nxt = m_instr_pc + 32'd4;
        m_valid = 1'b0;
        if (nxt[1:0] != 2'b00) begin
            m_mis = 1'b1; m_halted = 1'b1;
        end else if (hlt) begin
            m_halted = 1'b1;
        end else begin
            m_pc = nxt; m_req = 1'b1;
        end
        $display("retire pc=0x%08h br=%0b j=%0b jr=%0b halt=%0b next=0x%08h",
                 m_instr_pc, br, jmp, jr, hlt, nxt);
    endtask

    task automatic ack_noise(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_ack = 1'b1; bus.imem_rdata = $urandom;
            @(posedge clk); #1;
        end
        bus.imem_ack = 1'b0;
        $display("ack noise for %0d cycles", cycles);
    endtask

    initial begin
        nRst = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        clear_ctrl();
        m_reset();

        do_reset(1'b0);
        // First fetch: ack one cycle after req, instruction visible the cycle after ack
        fetch(32'h0, 32'h0000_0013, 1);
        @(negedge clk);
        chk("first_instr_lit", bus.instr, 32'h0000_0013);
        chk("first_instr_pc_lit", bus.instr_pc, 32'h0);
        chk("first_valid_lit", 32'(bus.instr_valid), 32'd1);
        @(posedge clk); #1;

        retire(0, 0, 0, 0, 32'h0, 32'h0, 0);
        fetch(32'h4, 32'h0040_0093, 0);
        retire(2, 0, 0, 0, 32'h0, 32'h0, 0);
        fetch(32'h8, 32'h0080_0113, 2);
        retire(0, 0, 0, 0, 32'h0, 32'h0, 0);
        fetch(32'hC, 32'h00C0_0193, 0);
        retire(1, 0, 0, 0, 32'h0, 32'h0, 0);
        fetch(32'h10, 32'hFE00_0CE3, 0);
        retire(0, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 0);
        fetch(32'h8, 32'h1000_006F, 1);
        retire(0, 0, 1, 0, 32'h0000_0100, 32'h0, 0);
        fetch(32'h108, 32'h0010_8067, 0);
        retire(0, 0, 0, 1, 32'h1, 32'h203, 0);
        fetch(32'h204, 32'h0040_8067, 0);
        retire(0, 0, 0, 1, 32'h4, 32'h201, 0);
        fetch(32'h204, 32'h00C0_8067, 0);
        retire(0, 0, 0, 1, 32'hC, 32'hFFFF_FFF0, 0);
        fetch(32'hFFFF_FFFC, 32'h0000_0013, 5);
        retire(0, 0, 0, 0, 32'h0, 32'h0, 0);
        fetch(32'h0, 32'h0020_8067, 0);
        retire(0, 0, 0, 1, 32'h2, 32'h200, 0);
        @(negedge clk);
        chk("mis_lit", 32'(bus.misaligned), 32'd1);
        chk("mis_halted_lit", 32'(bus.halted), 32'd1);
        @(posedge clk); #1;
        ack_noise(3);

        do_reset(1'b0);
        do_reset(1'b1);
        @(negedge clk);
        chk("reset_ack_valid_lit", 32'(bus.instr_valid), 32'd0);
        @(posedge clk); #1;
        fetch(RESET_PC, 32'h0010_0073, 0);
        retire(0, 0, 0, 0, 32'h0, 32'h0, 1);
        ack_noise(4);
        @(negedge clk);
        chk("halt_halted_lit", 32'(bus.halted), 32'd1);
        chk("halt_req_lit", 32'(bus.imem_req), 32'd0);
        chk("halt_mis_lit", 32'(bus.misaligned), 32'd0);
        @(posedge clk); #1;

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
